dprintf_framebuffer_writer: RTL and testbench

DPRINTF_FRAMEBUFFER_WRITER -- requirements
Module: dprintf_framebuffer_writer

---
 rtl/dprintf_pkg.sv | 40 ++++
 rtl/dprintf_byte_decode.sv | 26 ++
 rtl/dprintf_framebuffer_writer.sv | 113 +++++++++++
 tb/tb_dprintf_framebuffer_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dprintf_pkg.sv
// Shared types and constants for the dprintf framebuffer path: request/write
// bundles, byte classes and the format-byte extraction helper.
package dprintf_pkg;

  localparam int          NUM_BYTES = 32;
  localparam logic [7:0]  BYTE_TERM = 8'h00;
  localparam logic [7:0]  LIT_HI    = 8'h7F;
  localparam logic [7:0]  HEX_LO    = 8'hC0;
  localparam logic [7:0]  HEX_HI    = 8'hCF;

  typedef enum logic [1:0] {BC_TERM, BC_LIT, BC_HEX, BC_SKIP} byte_class_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_ACK} fsm_state_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] address;
    logic [63:0] data_0;
    logic [63:0] data_1;
    logic [63:0] data_2;
    logic [63:0] data_3;
  } dprintf_req_4;

  typedef struct packed {
    logic        valid;
    logic [15:0] address;
    logic [7:0]  data;
  } byte_write;

  // Byte 0 sits in the top bits of the 256-bit format word.
  function automatic logic [7:0] get_byte(input logic [255:0] d, input logic [4:0] idx);
    logic [255:0] s;
    s = d << (8 * idx);
    return s[255:248];
  endfunction

  function automatic logic is_writable(input byte_class_e c);
    return (c == BC_LIT) || (c == BC_HEX);
  endfunction

endpackage

// File: rtl/dprintf_byte_decode.sv
// Classifies one format byte and produces the character it prints.
module dprintf_byte_decode
  import dprintf_pkg::*;
(
  input  logic [7:0]  byte_i,
  output byte_class_e cls_o,
  output logic [7:0]  char_o
);

  always_comb begin
    cls_o  = BC_SKIP;
    char_o = 8'h00;
    if (byte_i == BYTE_TERM) begin
      cls_o = BC_TERM;
    end else if (byte_i <= LIT_HI) begin
      cls_o  = BC_LIT;
      char_o = byte_i;
    end else if (byte_i >= HEX_LO && byte_i <= HEX_HI) begin
      cls_o  = BC_HEX;
      // 0x57 + 10 = 'a'
      char_o = (byte_i[3:0] < 4'd10) ? (8'h30 + {4'h0, byte_i[3:0]})
                                     : (8'h57 + {4'h0, byte_i[3:0]});
    end
  end

endmodule

// File: rtl/dprintf_framebuffer_writer.sv
// Walks a 32-byte dprintf format word and streams printable characters into
// the framebuffer, one byte per cycle when the sink is always ready.
module dprintf_framebuffer_writer
  import dprintf_pkg::*;
(
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic        dprintf_req__valid,
  input  logic [15:0] dprintf_req__address,
  input  logic [63:0] dprintf_req__data_0,
  input  logic [63:0] dprintf_req__data_1,
  input  logic [63:0] dprintf_req__data_2,
  input  logic [63:0] dprintf_req__data_3,
  output logic        dprintf_ack,
  output logic        byte_write__valid,
  output logic [15:0] byte_write__address,
  output logic [7:0]  byte_write__data,
  input  logic        byte_write_ready
);

  dprintf_req_4 req;
  assign req = {dprintf_req__valid, dprintf_req__address, dprintf_req__data_0,
                dprintf_req__data_1, dprintf_req__data_2, dprintf_req__data_3};

  fsm_state_e   state_q, state_d;
  logic         hold_q, hold_d;
  logic [4:0]   idx_q, idx_d;
  logic [255:0] data_q, data_d;
  byte_class_e  cls_q, cls_d;
  byte_write    bw_q, bw_d;

  // The decoder always looks one byte ahead so the output registers are
  // loaded with the next character on the same edge that retires the current.
  logic [7:0]  nxt_byte, nxt_char;
  byte_class_e nxt_cls;
  logic        capture, hs, skip, advance, last;

  assign capture  = (state_q == ST_IDLE) && req.valid && !hold_q;
  assign hs       = bw_q.valid && byte_write_ready;
  assign skip     = (state_q == ST_EMIT) && (cls_q == BC_SKIP);
  assign advance  = hs || skip;
  assign last     = (idx_q == 5'(NUM_BYTES - 1));
  assign nxt_byte = (state_q == ST_IDLE)
                  ? get_byte({req.data_0, req.data_1, req.data_2, req.data_3}, 5'd0)
                  : get_byte(data_q, idx_q + 5'd1);

  dprintf_byte_decode u_decode (
    .byte_i (nxt_byte),
    .cls_o  (nxt_cls),
    .char_o (nxt_char)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      cls_q   <= BC_TERM;
      bw_q    <= '0;
    end else if (clk__enable) begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cls_q   <= cls_d;
      bw_q    <= bw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (capture) state_d = ST_EMIT;
      ST_EMIT: if (cls_q == BC_TERM || (advance && last)) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Upstream drops valid one cycle late, so the first idle cycle after ack
  // never captures.
  always_comb begin
    hold_d = (state_q == ST_ACK);
    idx_d  = idx_q;
    data_d = data_q;
    cls_d  = cls_q;
    bw_d   = bw_q;
    if (capture) begin
      data_d     = {req.data_0, req.data_1, req.data_2, req.data_3};
      idx_d      = 5'd0;
      cls_d      = nxt_cls;
      bw_d.valid = is_writable(nxt_cls);
      bw_d.address = req.address;
      bw_d.data  = nxt_char;
    end else if (advance) begin
      idx_d      = idx_q + 5'd1;
      cls_d      = nxt_cls;
      bw_d.valid = !last && is_writable(nxt_cls);
      bw_d.data  = nxt_char;
      if (hs) bw_d.address = bw_q.address + 16'd1;
    end
  end

  always_comb begin
    dprintf_ack         = (state_q == ST_ACK);
    byte_write__valid   = bw_q.valid;
    byte_write__address = bw_q.address;
    byte_write__data    = bw_q.data;
  end

endmodule

// File: tb/tb_dprintf_framebuffer_writer.sv
// Directed scoreboard bench: stimulus pushes expected writes/acks, a negedge
// monitor pops and compares them, including cycle spacing between events.
module tb_dprintf_framebuffer_writer;

  logic        clk = 1'b0;
  logic        clk__enable = 1'b1;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic        ack, bw_valid;
  logic [15:0] bw_addr;
  logic [7:0]  bw_data;
  logic        ready = 1'b1;

  dprintf_framebuffer_writer dut (
    .clk                  (clk),
    .clk__enable          (clk__enable),
    .reset                (reset),
    .dprintf_req__valid   (req_valid),
    .dprintf_req__address (req_addr),
    .dprintf_req__data_0  (d0),
    .dprintf_req__data_1  (d1),
    .dprintf_req__data_2  (d2),
    .dprintf_req__data_3  (d3),
    .dprintf_ack          (ack),
    .byte_write__valid    (bw_valid),
    .byte_write__address  (bw_addr),
    .byte_write__data     (bw_data),
    .byte_write_ready     (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_ack;
    logic [15:0] addr;
    logic [7:0]  data;
    int          gap;   // required cycles since previous event, 0 = any
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   last_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bw_valid && ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h want none", bw_addr, bw_data);
        end else begin
          e = sb.pop_front();
          chk("event_is_write", {31'b0, e.is_ack}, 32'd0);
          chk("wr_addr", {16'b0, bw_addr}, {16'b0, e.addr});
          chk("wr_data", {24'b0, bw_data}, {24'b0, e.data});
          if (e.gap != 0) chk("wr_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
      if (ack) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack=1 want none");
        end else begin
          e = sb.pop_front();
          chk("event_is_ack", {31'b0, e.is_ack}, 32'd1);
          if (e.gap != 0) chk("ack_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic push_w(input logic [15:0] a, input logic [7:0] d, input int gap);
    exp_t e;
    e.is_ack = 1'b0; e.addr = a; e.data = d; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_ack(input int gap);
    exp_t e;
    e.is_ack = 1'b1; e.addr = '0; e.data = '0; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic [15:0] a, input logic [7:0] b [32]);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[255 - 8*i -: 8] = b[i];
    {d0, d1, d2, d3} = w;
    req_addr  = a;
    req_valid = 1'b1;
  endtask

  // Wait for ack, then behave like the upstream requester: valid drops one
  // cycle after the ack cycle.
  task automatic wait_ack_release(input string nm);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (ack) break;
      n++;
    end
    if (n == 200) chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ack"},   {31'b0, ack}, 32'd0);
    chk({nm, "_valid"}, {31'b0, bw_valid}, 32'd0);
    chk({nm, "_addr"},  {16'b0, bw_addr}, 32'd0);
    chk({nm, "_data"},  {24'b0, bw_data}, 32'd0);
  endtask

  logic [7:0]  b [32];
  logic [15:0] a;
  int          n;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // "Hi" at 0x0100, back-to-back writes then ack after the terminator cycle
    foreach (b[i]) b[i] = 8'h00;
    b[0] = 8'h48; b[1] = 8'h69;
    push_w(16'h0100, 8'h48, 0); push_w(16'h0101, 8'h69, 1); push_ack(2);
    set_req(16'h0100, b);
    wait_ack_release("hi");

    // New request right after the stale-valid cycle; hex, skip, literal
    foreach (b[i]) b[i] = 8'h00;
    b[0] = 8'hC3; b[1] = 8'hCA; b[2] = 8'hFF; b[3] = 8'h21;
    push_w(16'h0200, 8'h33, 0); push_w(16'h0201, 8'h61, 1);
    push_w(16'h0202, 8'h21, 2); push_ack(2);
    set_req(16'h0200, b);
    wait_ack_release("hex");

    // 32 literals with address wrap, no terminator
    foreach (b[i]) b[i] = 8'h41;
    a = 16'hFFFE;
    for (int i = 0; i < 32; i++) begin
      push_w(a, 8'h41, (i == 0) ? 0 : 1);
      a = a + 16'd1;
    end
    push_ack(1);
    set_req(16'hFFFE, b);
    wait_ack_release("full");

    // Backpressure: first write held 5 cycles, one-cycle capture latency
    foreach (b[i]) b[i] = 8'h00;
    b[0] = 8'h4F; b[1] = 8'h6B;
    ready = 1'b0;
    push_w(16'h0400, 8'h4F, 0); push_w(16'h0401, 8'h6B, 1); push_ack(2);
    set_req(16'h0400, b);
    @(negedge clk);
    chk("stall_pre_valid", {31'b0, bw_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, bw_valid}, 32'd1);
      chk("stall_addr", {16'b0, bw_addr}, 32'h0400);
      chk("stall_data", {24'b0, bw_data}, 32'h4F);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_ack_release("stall");

    // Reset while the third write is presented; request is replayed
    foreach (b[i]) b[i] = 8'h00;
    b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43; b[3] = 8'h44; b[4] = 8'h45;
    push_w(16'h0300, 8'h41, 0); push_w(16'h0301, 8'h42, 1);
    set_req(16'h0300, b);
    n = 0;
    while (n < 50) begin
      @(posedge clk); #1;
      if (bw_valid && bw_addr == 16'h0302) break;
      n++;
    end
    if (n == 50) chk("third_write_timeout", 32'd0, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreq");
    chk("pre_reset_pending", sb.size(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_w(16'h0300, 8'h41, 0);
    for (int i = 1; i < 5; i++) push_w(16'h0300 + 16'(i), 8'h41 + 8'(i), 1);
    push_ack(2);
    wait_ack_release("replay");

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
